// File: rtl/wb_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 Wishbone arbiter: owner-state encodings
// and the Wishbone cycle-type constants used on the slave port.
package wb_arbiter_2to1_pkg;

  // Owner state. Only one master can hold the bus at any time.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Wishbone B3 cycle-type identifiers.
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Hung-slave watchdog for the 2:1 Wishbone arbiter. Present only when
// WB_ARB_TIMEOUT_EN is defined.
// timeout is high in the cycle where the count of consecutive unanswered
// strobe cycles reaches TIMEOUT_CYCLES; the count then restarts from zero.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic resp,
  input  logic owner_change,
  output logic timeout
);

  logic [7:0] cnt_q;

  assign timeout = stb && (cnt_q == 8'(TIMEOUT_CYCLES));

  // Count stalled strobe cycles; any response, owner change, idle strobe or firing restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (timeout || !stb || resp || owner_change) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone B3 arbiter.
// Master 0 is the D-side BIU, master 1 the I-side hierarchy. Round-robin,
// bus-cycle atomic: the owner keeps the bus until it drops its cyc.
// Handshake: a master requests with m_cyc_i; once it owns the bus its
// stb/we/adr/dat/sel/cti/bte pass straight to the slave, and the slave's
// ack/err/rty/dat come straight back to the owner in the same cycle. The
// non-owner never sees a response.
// Optional feature: define WB_ARB_TIMEOUT_EN to build the hung-slave
// watchdog, which turns TIMEOUT_CYCLES stalled strobes into a one-cycle err.
module wb_arbiter_2to1
  import wb_arbiter_2to1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [63:0] m_adr_i,
  input  logic [7:0]  m_sel_i,
  input  logic [63:0] m_dat_i,
  input  logic [5:0]  m_cti_i,
  input  logic [3:0]  m_bte_i,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [1:0]  m_rty_o,
  output logic [63:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  input  logic [31:0] s_dat_i
);

  owner_e owner_q, owner_d;
  logic   last_q, last_d;
  logic   owned;
  logic   own_sel;
  logic   owner_cyc;
  logic   rearb;
  logic   timeout;

  assign owned     = (owner_q != OWN_IDLE);
  assign own_sel   = (owner_q == OWN_M1);
  assign owner_cyc = m_cyc_i[own_sel];
  assign rearb     = !owned || !owner_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .stb         (s_stb_o),
    .resp        (s_ack_i | s_err_i | s_rty_i),
    .owner_change(owner_d != owner_q),
    .timeout     (timeout)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  // Owner state and previous-owner bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IDLE;
      last_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Round-robin arbitration, only when the bus is idle or the owner has released it.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    if (rearb) begin
      case (m_cyc_i)
        2'b00: owner_d = OWN_IDLE;
        2'b01: begin
          owner_d = OWN_M0;
          last_d  = 1'b0;
        end
        2'b10: begin
          owner_d = OWN_M1;
          last_d  = 1'b1;
        end
        default: begin
          if (last_q) begin
            owner_d = OWN_M0;
            last_d  = 1'b0;
          end else begin
            owner_d = OWN_M1;
            last_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // Zero-latency mux of the owner's request onto the slave port and of the slave response back.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    s_cti_o = CTI_CLASSIC;
    s_bte_o = 2'd0;
    m_ack_o = 2'b00;
    m_err_o = 2'b00;
    m_rty_o = 2'b00;
    m_dat_o = 64'd0;
    if (owned) begin
      s_cyc_o = owner_cyc;
      s_stb_o = m_stb_i[own_sel];
      s_we_o  = m_we_i[own_sel];
      s_adr_o = own_sel ? m_adr_i[63:32] : m_adr_i[31:0];
      s_dat_o = own_sel ? m_dat_i[63:32] : m_dat_i[31:0];
      s_sel_o = own_sel ? m_sel_i[7:4]   : m_sel_i[3:0];
      s_cti_o = own_sel ? m_cti_i[5:3]   : m_cti_i[2:0];
      s_bte_o = own_sel ? m_bte_i[3:2]   : m_bte_i[1:0];
      // A watchdog error replaces any ack arriving in the same cycle.
      m_ack_o[own_sel] = s_ack_i & ~timeout;
      m_err_o[own_sel] = s_err_i | timeout;
      m_rty_o[own_sel] = s_rty_i;
      if (own_sel) begin
        m_dat_o[63:32] = s_dat_i;
      end else begin
        m_dat_o[31:0] = s_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: directed scenarios followed by
// random traffic, all checked cycle by cycle against a behavioural model.
module tb_wb_arbiter_2to1;
  import wb_arbiter_2to1_pkg::*;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc, stb, we;
  logic [63:0] adr, dat;
  logic [7:0]  sel;
  logic [5:0]  cti;
  logic [3:0]  bte;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_rdat;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [63:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: owner is -1 (none), 0 or 1; last is the previous grantee.
  int own  = -1;
  int last = 0;
  int cnt  = 0;

  wb_arbiter_2to1 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_adr_i(adr), .m_sel_i(sel),
    .m_dat_i(dat), .m_cti_i(cti), .m_bte_i(bte),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_rdat)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_timeout();
    bit to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    if (own >= 0) to = stb[own] && (cnt == TO);
`endif
    return to;
  endfunction

  // Compare every DUT output against what the model says this cycle.
  task automatic check_all();
    logic [75:0] exp_s;
    logic [69:0] exp_m;
    logic [1:0]  r_ack, r_err, r_rty;
    logic [63:0] r_dat;
    bit          to;
    exp_s = '0;
    r_ack = 2'b00; r_err = 2'b00; r_rty = 2'b00; r_dat = 64'd0;
    to = model_timeout();
    if (own >= 0) begin
      exp_s = {cyc[own], stb[own], we[own], adr[own*32 +: 32], dat[own*32 +: 32],
               sel[own*4 +: 4], cti[own*3 +: 3], bte[own*2 +: 2]};
      r_ack[own] = s_ack & ~to;
      r_err[own] = s_err | to;
      r_rty[own] = s_rty;
      r_dat[own*32 +: 32] = s_rdat;
    end
    exp_m = {r_ack, r_err, r_rty, r_dat};
    check("slave_side", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o}, exp_s);
    check("master_side", {m_ack_o, m_err_o, m_rty_o, m_dat_o}, exp_m);
  endtask

  // Model state update at a clock edge, from the inputs present at that edge.
  task automatic model_edge();
    int  nxt;
    bit  to, stb_e, resp;
    if (rst) begin
      own = -1; last = 0; cnt = 0;
      return;
    end
    to    = model_timeout();
    stb_e = (own >= 0) && stb[own];
    resp  = s_ack | s_err | s_rty;
    nxt   = own;
    if (own < 0 || !cyc[own]) begin
      if (cyc == 2'b00) nxt = -1;
      else if (cyc == 2'b01) nxt = 0;
      else if (cyc == 2'b10) nxt = 1;
      else nxt = 1 - last;
      if (nxt >= 0) last = nxt;
    end
    if (to || !stb_e || resp || nxt != own) cnt = 0;
    else cnt++;
    own = nxt;
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    cyc = 2'b00; stb = 2'b00; we = 2'b00; adr = '0; dat = '0; sel = '0;
    cti = '0; bte = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    own = -1; last = 0; cnt = 0;
    repeat (2) advance();
    rst = 1'b0;
    settle();
    check("reset_s_cyc", s_cyc_o, 1'b0);
    advance();
  endtask

  int err_pulses;
  int first_err;

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // D-side classic read of 0x1000, slave acks in the third cycle.
    cyc = 2'b01; stb = 2'b01; sel = 8'h0F; adr[31:0] = 32'h0000_1000; cti[2:0] = CTI_CLASSIC;
    settle();
    check("grant_latency_idle", s_cyc_o, 1'b0);
    advance();
    settle();
    check("d_read_adr", s_adr_o, 32'h0000_1000);
    advance();
    s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
    settle();
    check("d_read_ack", m_ack_o, 2'b01);
    check("d_read_dat", m_dat_o, 64'h0000_0000_CAFE_F00D);
    advance();
    idle_inputs();
    settle(); advance();

    // Tie after reset: master 1 first, then master 0 with no idle gap.
    do_reset();
    cyc = 2'b11; stb = 2'b11; adr = {32'h2000_0000, 32'h1000_0000};
    settle(); advance();
    settle();
    check("tie_first_m1", s_adr_o, 32'h2000_0000);
    advance();
    cyc = 2'b01; stb = 2'b01;
    settle(); advance();
    settle();
    check("handover_cyc", s_cyc_o, 1'b1);
    check("handover_adr", s_adr_o, 32'h1000_0000);
    advance();
    idle_inputs();
    settle(); advance();

    // I-side 8-beat burst; D-side requests mid-burst and must wait.
    cyc = 2'b10; stb = 2'b10; sel = 8'hF0; cti[5:3] = CTI_INCR; adr[63:32] = 32'h0000_4000;
    settle(); advance();
    for (int b = 0; b < 8; b++) begin
      adr[63:32] = 32'h0000_4000 + 32'(b * 4);
      cti[5:3]   = (b == 7) ? CTI_EOB : CTI_INCR;
      s_ack = 1'b1; s_rdat = $urandom;
      if (b == 3) begin
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[31:0] = 32'h0000_8000;
      end
      settle();
      check("burst_no_d_ack", m_ack_o[0], 1'b0);
      check("burst_adr", s_adr_o, 32'h0000_4000 + 32'(b * 4));
      advance();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
    settle(); advance();
    settle();
    check("after_burst_d_adr", s_adr_o, 32'h0000_8000);
    advance();
    idle_inputs();
    settle(); advance();

    // Asynchronous reset mid-burst with a stalled slave.
    cyc = 2'b10; stb = 2'b10; adr[63:32] = 32'h0000_C000; cti[5:3] = CTI_INCR;
    repeat (3) begin settle(); advance(); end
    @(negedge clk); #2;
    rst = 1'b1; own = -1; last = 0; cnt = 0;
    #1;
    check("async_rst_cyc", s_cyc_o, 1'b0);
    check("async_rst_stb", s_stb_o, 1'b0);
    @(posedge clk); model_edge(); #1;
    rst = 1'b0;
    cyc = 2'b11; stb = 2'b11; adr = {32'h0000_C100, 32'h0000_0100};
    settle(); advance();
    settle();
    check("tie_after_rst_m1", s_adr_o, 32'h0000_C100);
    advance();
    idle_inputs();
    settle(); advance();

    // Hung slave on a D-side write.
    cyc = 2'b01; stb = 2'b01; we = 2'b01; dat[31:0] = 32'h1234_5678; adr[31:0] = 32'h0000_0040;
    settle(); advance();
    err_pulses = 0; first_err = 0;
    for (int c = 1; c <= 9; c++) begin
      settle();
      if (m_err_o != 2'b00) begin
        err_pulses++;
        if (first_err == 0) first_err = c;
      end
      advance();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wd_pulses", err_pulses, 1);
    check("wd_first_cycle", first_err, 5);
`else
    check("no_wd_pulses", err_pulses, 0);
`endif
    idle_inputs();
    settle(); advance();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) begin
          if ($urandom_range(0, 3) == 0) begin
            cyc[m] = 1'b1;
            stb[m] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          cyc[m] = 1'b0; stb[m] = 1'b0;
        end else begin
          stb[m] = ($urandom_range(0, 3) != 0);
        end
        we[m] = 1'($urandom_range(0, 1));
        adr[m*32 +: 32] = $urandom;
        dat[m*32 +: 32] = $urandom;
        sel[m*4 +: 4]   = 4'($urandom_range(0, 15));
        cti[m*3 +: 3]   = 3'($urandom_range(0, 7));
        bte[m*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      s_ack  = ($urandom_range(0, 2) == 0);
      s_err  = ($urandom_range(0, 9) == 0);
      s_rty  = ($urandom_range(0, 9) == 0);
      s_rdat = $urandom;
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
